// File: rtl/chargen_pkg.sv
// Shared definitions for the character-generator write path: screen
// geometry, control-character codes, controller states, cursor operations
// and the packed {row, col} cursor/address type.
package chargen_pkg;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int COL_W = 7;
  localparam int ROW_W = 5;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_BS    = 8'h08;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_ADV,
    OP_LF,
    OP_CR,
    OP_BS,
    OP_HOME
  } cur_op_t;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } cursor_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/char_cursor.sv
// Text cursor register. Applies one operation per cycle (advance with
// line wrap, newline, carriage return, backspace, home) and keeps the
// position inside the visible COLS x ROWS area at all times.
module char_cursor
  import chargen_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  cur_op_t op,
  output cursor_t pos
);

  // Row after a line step; wraps from the last row back to the top, no scrolling.
  function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] r);
    return (r == LAST_ROW) ? '0 : r + 1'b1;
  endfunction

  // Cursor position update, driven by the operation the controller selects.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pos <= '0;
    end else begin
      case (op)
        OP_ADV: begin
          if (pos.col == LAST_COL) begin
            pos.col <= '0;
            pos.row <= next_row(pos.row);
          end else begin
            pos.col <= pos.col + 1'b1;
          end
        end
        OP_LF:   pos.row <= next_row(pos.row);
        OP_CR:   pos.col <= '0;
        OP_BS:   if (pos.col != '0) pos.col <= pos.col - 1'b1;
        OP_HOME: pos <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/char_write_ctrl.sv
// Character memory write sequencer/arbiter. Merges UART bytes and manual
// writes into one write per cycle, tracks the text cursor, runs the
// full-screen clear sweep and parks one UART byte while busy or outranked.
// Optional cursor blink is enabled with the macro CHARGEN_CURSOR_BLINK_EN.
module char_write_ctrl
  import chargen_pkg::*;
#(
  parameter int BLINK_CYCLES = 50_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   uart_valid,
  input  logic [7:0]             uart_data,
  input  logic                   man_we,
  input  logic [7:0]             man_char,
  input  logic                   clr_req,
  output logic                   mem_we,
  output logic [COL_W+ROW_W-1:0] mem_addr,
  output logic [7:0]             mem_data,
  output logic [COL_W-1:0]       cur_col,
  output logic [ROW_W-1:0]       cur_row,
  output logic                   busy,
  output logic                   ovf,
  output logic                   cur_vis
);

  if (BLINK_CYCLES < 2) begin : g_bad_blink
    $error("BLINK_CYCLES must be at least 2");
  end

  state_t           state;
  logic             pend_valid;
  logic [7:0]       pend_data;
  logic [ROW_W-1:0] clr_row;
  logic [COL_W-1:0] clr_col;
  logic             clr_done;

  cursor_t          pos;
  cur_op_t          cur_op;
  logic             sel_valid;
  logic [7:0]       sel_byte;
  logic             park_uart;

  char_cursor u_cursor (
    .clk (clk),
    .rst (rst),
    .op  (cur_op),
    .pos (pos)
  );

  assign cur_row = pos.row;
  assign cur_col = pos.col;

  // Pick this cycle's byte by priority and translate it into a cursor operation.
  always_comb begin
    sel_valid = 1'b0;
    sel_byte  = '0;
    cur_op    = OP_NONE;
    park_uart = uart_valid && ((state == CLEAR) || clr_req);
    if (state == IDLE && !clr_req) begin
      if (pend_valid) begin
        sel_valid = 1'b1;
        sel_byte  = pend_data;
      end else if (uart_valid) begin
        sel_valid = 1'b1;
        sel_byte  = uart_data;
      end else if (man_we) begin
        sel_valid = 1'b1;
        sel_byte  = man_char;
      end
    end
    if (state == CLEAR && clr_done) begin
      cur_op = OP_HOME;
    end else if (sel_valid) begin
      if (is_printable(sel_byte))                        cur_op = OP_ADV;
      else if (sel_byte == CH_CR)                        cur_op = OP_CR;
      else if (sel_byte == CH_LF)                        cur_op = OP_LF;
      else if (sel_byte == CH_BS && pos.col != '0)       cur_op = OP_BS;
    end
  end

  // Controller FSM: registered write port, clear sweep, pending byte and overflow flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      busy       <= 1'b0;
      ovf        <= 1'b0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      clr_row    <= '0;
      clr_col    <= '0;
      clr_done   <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            busy     <= 1'b1;
            mem_we   <= 1'b1;
            mem_addr <= '0;
            mem_data <= CH_SPACE;
            clr_row  <= '0;
            clr_col  <= COL_W'(1);
            clr_done <= 1'b0;
          end else begin
            if (pend_valid) begin
              pend_valid <= uart_valid;
              if (uart_valid) pend_data <= uart_data;
            end
            if (cur_op == OP_ADV) begin
              mem_we   <= 1'b1;
              mem_addr <= pos;
              mem_data <= sel_byte;
            end else if (cur_op == OP_BS) begin
              mem_we   <= 1'b1;
              mem_addr <= {pos.row, pos.col - 1'b1};
              mem_data <= CH_SPACE;
            end
          end
        end
        CLEAR: begin
          if (clr_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            mem_we   <= 1'b1;
            mem_addr <= {clr_row, clr_col};
            mem_data <= CH_SPACE;
            clr_done <= (clr_row == LAST_ROW) && (clr_col == LAST_COL);
            if (clr_col == LAST_COL) begin
              clr_col <= '0;
              clr_row <= clr_row + 1'b1;
            end else begin
              clr_col <= clr_col + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (park_uart) begin
        if (!pend_valid) begin
          pend_valid <= 1'b1;
          pend_data  <= uart_data;
        end else begin
          ovf <= 1'b1;
        end
      end
    end
  end

`ifdef CHARGEN_CURSOR_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_CYCLES);

  logic [BLINK_W-1:0] blink_cnt;
  logic               vis_q;

  // Blink timer; any cursor movement restarts it with the cursor shown.
  always_ff @(posedge clk) begin
    if (!rst) begin
      blink_cnt <= '0;
      vis_q     <= 1'b1;
    end else if (cur_op != OP_NONE) begin
      blink_cnt <= '0;
      vis_q     <= 1'b1;
    end else if (blink_cnt == BLINK_W'(BLINK_CYCLES - 1)) begin
      blink_cnt <= '0;
      vis_q     <= ~vis_q;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign cur_vis = vis_q;
`else
  assign cur_vis = 1'b1;
`endif

endmodule

// File: tb/tb_char_write_ctrl.sv
// Testbench for char_write_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a screen-level behavioural model.
module tb_char_write_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        uart_valid = 1'b0;
  logic [7:0]  uart_data = '0;
  logic        man_we = 1'b0;
  logic [7:0]  man_char = '0;
  logic        clr_req = 1'b0;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;
  logic        busy;
  logic        ovf;
  logic        cur_vis;

  int total = 0;
  int bad   = 0;

  char_write_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .uart_valid (uart_valid),
    .uart_data  (uart_data),
    .man_we     (man_we),
    .man_char   (man_char),
    .clr_req    (clr_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .cur_col    (cur_col),
    .cur_row    (cur_row),
    .busy       (busy),
    .ovf        (ovf),
    .cur_vis    (cur_vis)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Behavioural model state: linear screen position arithmetic plus a pending queue.
  bit         model_ok = 1'b0;
  bit         m_we, m_busy, m_ovf, in_clear;
  int         m_row, m_col, m_addr, m_data, clr_pos;
  logic [7:0] pend_q[$];

  function automatic void model_write(int r, int c, int d);
    m_we   = 1'b1;
    m_addr = r * 128 + c;
    m_data = d;
  endfunction

  function automatic void model_byte(logic [7:0] b);
    int idx;
    if (b >= 8'h20 && b <= 8'h7E) begin
      model_write(m_row, m_col, int'(b));
      idx   = (m_row * 80 + m_col + 1) % 2400;
      m_row = idx / 80;
      m_col = idx % 80;
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h0A) begin
      m_row = (m_row + 1) % 30;
    end else if (b == 8'h08 && m_col > 0) begin
      m_col = m_col - 1;
      model_write(m_row, m_col, 32);
    end
  endfunction

  function automatic void model_park(logic v, logic [7:0] d);
    if (v) begin
      if (pend_q.size() == 0) pend_q.push_back(d);
      else m_ovf = 1'b1;
    end
  endfunction

  // Advance the model on each active edge from the inputs the DUT samples.
  always @(posedge clk) begin
    if (!rst) begin
      model_ok = 1'b1;
      m_we = 0; m_busy = 0; m_ovf = 0; in_clear = 0;
      m_row = 0; m_col = 0; m_addr = 0; m_data = 0; clr_pos = 0;
      pend_q.delete();
    end else if (model_ok) begin
      m_we = 1'b0;
      if (in_clear) begin
        if (clr_pos == 2400) begin
          in_clear = 1'b0;
          m_busy   = 1'b0;
          m_row    = 0;
          m_col    = 0;
        end else begin
          model_write(clr_pos / 80, clr_pos % 80, 32);
          clr_pos++;
        end
        model_park(uart_valid, uart_data);
      end else if (clr_req) begin
        in_clear = 1'b1;
        m_busy   = 1'b1;
        model_write(0, 0, 32);
        clr_pos  = 1;
        model_park(uart_valid, uart_data);
      end else if (pend_q.size() != 0) begin
        model_byte(pend_q.pop_front());
        if (uart_valid) pend_q.push_back(uart_data);
      end else if (uart_valid) begin
        model_byte(uart_data);
      end else if (man_we) begin
        model_byte(man_char);
      end
    end
  end

  logic [35:0] act_vec, exp_vec;

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      act_vec = {mem_we, (m_we ? mem_addr : 12'h0), (m_we ? mem_data : 8'h0),
                 cur_row, cur_col, busy, ovf, cur_vis};
      exp_vec = {m_we, (m_we ? 12'(m_addr) : 12'h0), (m_we ? 8'(m_data) : 8'h0),
                 5'(m_row), 7'(m_col), m_busy, m_ovf, 1'b1};
      total++;
      if (act_vec !== exp_vec) begin
        bad++;
        $display("[TB] FAIL model_cycle t=%0t actual=%h required=%h", $time, act_vec, exp_vec);
      end
    end
  end

  // Clear-sweep observers used by the directed clear scenario.
  bit mon_en = 1'b0;
  bit saw32  = 1'b0;
  int busy_cnt = 0;
  int clr_wr   = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy) busy_cnt++;
      if (busy && mem_we && mem_data == 8'h20) clr_wr++;
      if (mem_we && mem_data == 8'h32) saw32 = 1'b1;
    end
  end

  task automatic apply_stimulus(input logic uv, input logic [7:0] ud,
                                input logic mw, input logic [7:0] mc, input logic cr);
    uart_valid = uv;
    uart_data  = ud;
    man_we     = mw;
    man_char   = mc;
    clr_req    = cr;
    @(posedge clk);
    #1;
    uart_valid = 1'b0;
    man_we     = 1'b0;
    clr_req    = 1'b0;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_clear_end();
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check_output("clear_ends", {31'd0, busy}, 32'd0);
  endtask

  function automatic logic [7:0] rand_byte();
    int r = $urandom_range(0, 9);
    case (r)
      0: return 8'h0D;
      1: return 8'h0A;
      2: return 8'h08;
      3: return 8'h05;
      4: return 8'h7F;
      default: return 8'(8'h20 + $urandom_range(0, 94));
    endcase
  endfunction

  // Watchdog so the run always ends.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] start");
    // Reset
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_we",   {31'd0, mem_we}, 32'd0);
    check_output("rst_addr", {20'd0, mem_addr}, 32'd0);
    check_output("rst_data", {24'd0, mem_data}, 32'd0);
    check_output("rst_cur",  {20'd0, cur_row, cur_col}, 32'd0);
    check_output("rst_flags", {29'd0, busy, ovf, cur_vis}, 32'd1);
    rst = 1'b1;
    idle(2);

    // First UART byte lands at the origin
    apply_stimulus(1'b1, 8'h41, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check_output("a_we",   {31'd0, mem_we}, 32'd1);
    check_output("a_addr", {20'd0, mem_addr}, 32'd0);
    check_output("a_data", {24'd0, mem_data}, 32'h41);
    check_output("a_cur",  {20'd0, cur_row, cur_col}, {20'd0, 5'd0, 7'd1});

    // Walk to the bottom-right corner, then type across the wrap point
    apply_stimulus(1'b1, 8'h0D, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 29; i++) apply_stimulus(1'b1, 8'h0A, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 79; i++) begin
      if (i % 2 == 0) apply_stimulus(1'b1, 8'(8'h21 + $urandom_range(0, 90)), 1'b0, 8'h00, 1'b0);
      else            apply_stimulus(1'b0, 8'h00, 1'b1, 8'(8'h21 + $urandom_range(0, 90)), 1'b0);
    end
    @(negedge clk);
    check_output("corner_cur", {20'd0, cur_row, cur_col}, {20'd0, 5'd29, 7'd79});
    apply_stimulus(1'b1, 8'h5A, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check_output("z_addr", {20'd0, mem_addr}, {20'd0, 5'd29, 7'd79});
    check_output("z_data", {24'd0, mem_data}, 32'h5A);
    check_output("z_wrap", {20'd0, cur_row, cur_col}, 32'd0);

    // Backspace, then CR/LF with no writes
    apply_stimulus(1'b1, 8'h41, 1'b0, 8'h00, 1'b0);
    apply_stimulus(1'b1, 8'h42, 1'b0, 8'h00, 1'b0);
    apply_stimulus(1'b1, 8'h08, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check_output("bs_we",   {31'd0, mem_we}, 32'd1);
    check_output("bs_addr", {20'd0, mem_addr}, {20'd0, 5'd0, 7'd1});
    check_output("bs_data", {24'd0, mem_data}, 32'h20);
    check_output("bs_cur",  {20'd0, cur_row, cur_col}, {20'd0, 5'd0, 7'd1});
    apply_stimulus(1'b1, 8'h0D, 1'b0, 8'h00, 1'b0);
    apply_stimulus(1'b1, 8'h0A, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check_output("crlf_we",  {31'd0, mem_we}, 32'd0);
    check_output("crlf_cur", {20'd0, cur_row, cur_col}, {20'd0, 5'd1, 7'd0});

    // Clear sweep with two UART bytes arriving while busy
    mon_en = 1'b1;
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    idle(9);
    apply_stimulus(1'b1, 8'h31, 1'b1, 8'h4D, 1'b1);
    idle(9);
    apply_stimulus(1'b1, 8'h32, 1'b0, 8'h00, 1'b0);
    wait_clear_end();
    check_output("clr_busy_cycles", busy_cnt, 32'd2400);
    check_output("clr_writes",      clr_wr, 32'd2400);
    check_output("clr_ovf",         {31'd0, ovf}, 32'd1);
    check_output("clr_home",        {20'd0, cur_row, cur_col}, 32'd0);
    @(negedge clk);
    check_output("pend_we",   {31'd0, mem_we}, 32'd1);
    check_output("pend_addr", {20'd0, mem_addr}, 32'd0);
    check_output("pend_data", {24'd0, mem_data}, 32'h31);
    idle(4);
    check_output("no_32", {31'd0, saw32}, 32'd0);
    mon_en = 1'b0;

    // UART beats a simultaneous manual write
    apply_stimulus(1'b1, 8'h0D, 1'b0, 8'h00, 1'b0);
    apply_stimulus(1'b1, 8'h55, 1'b1, 8'h4D, 1'b0);
    @(negedge clk);
    check_output("arb_addr", {20'd0, mem_addr}, 32'd0);
    check_output("arb_data", {24'd0, mem_data}, 32'h55);
    idle(1);
    @(negedge clk);
    check_output("arb_drop", {31'd0, mem_we}, 32'd0);
    check_output("arb_cur",  {20'd0, cur_row, cur_col}, {20'd0, 5'd0, 7'd1});

    // Randomized traffic from a clean state
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(($urandom % 3) == 0, rand_byte(), ($urandom % 4) == 0, rand_byte(),
                     ($urandom % 300) == 0);
    end
    wait_clear_end();
    idle(3);

    // Reset in the middle of a sweep
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    apply_stimulus(1'b1, 8'h37, 1'b0, 8'h00, 1'b0);
    apply_stimulus(1'b1, 8'h38, 1'b0, 8'h00, 1'b0);
    idle(50);
    @(negedge clk);
    check_output("mid_busy", {30'd0, busy, ovf}, 32'd3);
    rst = 1'b0;
    idle(1);
    @(negedge clk);
    check_output("mid_rst_we",    {31'd0, mem_we}, 32'd0);
    check_output("mid_rst_addr",  {20'd0, mem_addr}, 32'd0);
    check_output("mid_rst_data",  {24'd0, mem_data}, 32'd0);
    check_output("mid_rst_cur",   {20'd0, cur_row, cur_col}, 32'd0);
    check_output("mid_rst_flags", {29'd0, busy, ovf, cur_vis}, 32'd1);
    rst = 1'b1;
    idle(2);
    apply_stimulus(1'b1, 8'h51, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check_output("post_rst_data", {23'd0, mem_we, mem_data}, {23'd0, 1'b1, 8'h51});
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
